// File: rtl/regfile_fwd_param_pkg.sv
// Shared types and helpers for the forwarding register file.
package regfile_fwd_param_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  // Width of one forwarding source slice: {we, waddr, result}
  function automatic int unsigned fwd_bus_wd(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/regfile_fwd_sel.sv
// Per-read-port operand select: zero register, youngest-first forwarding,
// write-through, then array value; flags a hazard when the winner is pending.
import regfile_fwd_param_pkg::*;

module regfile_fwd_sel #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_FWD  = 3,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]                                raddr,
  input  logic [NUM_FWD*fwd_bus_wd(ADDR_W, DATA_W)-1:0]    fwd_bus,
  input  logic [NUM_FWD-1:0]                               fwd_pending,
  input  logic                                             we,
  input  logic [ADDR_W-1:0]                                waddr,
  input  logic [DATA_W-1:0]                                wdata,
  input  logic [DATA_W-1:0]                                arr_data,
  output logic [DATA_W-1:0]                                data,
  output logic                                             hazard
);

  localparam int unsigned FWD_W = fwd_bus_wd(ADDR_W, DATA_W);

  logic [FWD_W-1:0] src;

  // Walk oldest to youngest so the youngest matching source is the last one applied
  always_comb begin
    data   = arr_data;
    hazard = 1'b0;
    src    = '0;
    if (we && (waddr == raddr)) begin
      data = wdata;
    end
    for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
      src = fwd_bus[k*FWD_W +: FWD_W];
      if (src[FWD_W-1] && (src[DATA_W +: ADDR_W] == raddr)) begin
        data   = src[DATA_W-1:0];
        hazard = fwd_pending[k];
      end
    end
    if ((ZERO_REG != 0) && (raddr == '0)) begin
      data   = '0;
      hazard = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_fwd_param.sv
// Register file with per-port forwarding, load-use stall request and
// a hardware clear sequence that holds the pipeline after reset.
import regfile_fwd_param_pkg::*;

module regfile_fwd_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_FWD  = 3,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [NUM_RD*ADDR_W-1:0]                         raddr,
  output logic [NUM_RD*DATA_W-1:0]                         rdata,
  input  logic [NUM_FWD*fwd_bus_wd(ADDR_W, DATA_W)-1:0]    fwd_bus,
  input  logic [NUM_FWD-1:0]                               fwd_pending,
  input  logic                                             we,
  input  logic [ADDR_W-1:0]                                waddr,
  input  logic [DATA_W-1:0]                                wdata,
  output logic                                             stall_req,
  output logic                                             init_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  rf_state_e          state;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               arr_we;
  logic [ADDR_W-1:0]  arr_waddr;
  logic [DATA_W-1:0]  arr_wdata;
  logic [NUM_RD-1:0]  hazard_vec;

  // Clear sequencer: one register per cycle, then hand over to RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_INIT;
      clr_cnt <= '0;
    end else if (state == RF_INIT) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
      if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
        state <= RF_RUN;
      end
    end
  end

  // Array write port is shared between the clear sequence and WB
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = waddr;
    arr_wdata = wdata;
    if (!rst) begin
      if (state == RF_INIT) begin
        arr_we    = 1'b1;
        arr_waddr = clr_cnt;
        arr_wdata = '0;
      end else if (we && !((ZERO_REG != 0) && (waddr == '0))) begin
        arr_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      mem[arr_waddr] <= arr_wdata;
    end
  end

  assign init_busy = rst | (state == RF_INIT);

  for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] sel_data;
    logic              sel_hazard;

    assign ra = raddr[i*ADDR_W +: ADDR_W];

    regfile_fwd_sel #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_FWD  (NUM_FWD),
      .ZERO_REG (ZERO_REG)
    ) u_sel (
      .raddr       (ra),
      .fwd_bus     (fwd_bus),
      .fwd_pending (fwd_pending),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
      .arr_data    (mem[ra]),
      .data        (sel_data),
      .hazard      (sel_hazard)
    );

    assign rdata[i*DATA_W +: DATA_W] = init_busy ? '0 : sel_data;
    assign hazard_vec[i]             = sel_hazard;
  end

  assign stall_req = init_busy | (|hazard_vec);

endmodule

// File: tb/tb_regfile_fwd_param.sv
// Directed bench for regfile_fwd_param: clear sequence, forwarding priority,
// load-use stall, zero register and write-through.
module tb_regfile_fwd_param;

  logic         clk;
  logic         rst;
  logic [9:0]   raddr;
  logic [63:0]  rdata;
  logic [113:0] fwd_bus;
  logic [2:0]   fwd_pending;
  logic         we;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic         stall_req;
  logic         init_busy;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_fwd_param dut (
    .clk         (clk),
    .rst         (rst),
    .raddr       (raddr),
    .rdata       (rdata),
    .fwd_bus     (fwd_bus),
    .fwd_pending (fwd_pending),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .stall_req   (stall_req),
    .init_busy   (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r0, r1;
    logic [2:0]  fwe;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  pend;
    logic        wwe;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] e0, e1;
    logic        es;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] r0, input logic [4:0] r1, input logic [2:0] fwe,
                              input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [2:0] pend, input logic wwe, input logic [4:0] wa,
                              input logic [31:0] wd, input logic [31:0] e0, input logic [31:0] e1,
                              input logic es);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.fwe = fwe; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.pend = pend; v.wwe = wwe; v.wa = wa;
    v.wd = wd; v.e0 = e0; v.e1 = e1; v.es = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic set_fwd(input logic [2:0] fwe, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2);
    fwd_bus = {fwe[2], a2, d2, fwe[1], a1, d1, fwe[0], a0, d0};
  endtask

  task automatic idle();
    set_fwd(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    fwd_pending = 3'b000;
    we = 1'b0;
    waddr = 5'd0;
    wdata = 32'h0;
  endtask

  // Counts posedges until init_busy falls, bounded
  task automatic count_init(output int n);
    n = 0;
    while (init_busy && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  vec_t vecs[13];

  initial begin
    int n;
    rst = 1'b1;
    raddr = 10'd0;
    idle();

    // First reset and clear
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_stall", 32'(stall_req), 32'd1);
    chk("rst_rdata", rdata[31:0], 32'h0);
    rst = 1'b0;
    count_init(n);
    chk("init_len_first", 32'(n), 32'd32);
    chk("run_stall_idle", 32'(stall_req), 32'd0);

    // Fill the array so the next clear has something to erase
    for (int i = 1; i < 32; i++) wb_write(5'(i), 32'h100 + 32'(i));
    @(negedge clk);
    raddr = {5'd31, 5'd3};
    #1;
    chk("fill_r3", rdata[31:0], 32'h103);
    chk("fill_r31", rdata[63:32], 32'h11F);

    // Second reset, reasserted mid-clear, with WB and forwarding active throughout
    @(negedge clk);
    rst = 1'b1;
    raddr = {5'd5, 5'd5};
    we = 1'b1; waddr = 5'd3; wdata = 32'h7;
    set_fwd(3'b001, 5'd5, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("init_busy_cyc10", 32'(init_busy), 32'd1);
    chk("init_rdata0", rdata[31:0], 32'h0);
    chk("init_stall", 32'(stall_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_init(n);
    chk("init_len_restart", 32'(n), 32'd32);
    idle();
    #1;
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(i), 5'(i)};
      #1;
      chk($sformatf("clear_p0_r%0d", i), rdata[31:0], 32'h0);
      chk($sformatf("clear_p1_r%0d", i), rdata[63:32], 32'h0);
    end

    wb_write(5'd5, 32'h55);
    wb_write(5'd8, 32'h88);
    wb_write(5'd9, 32'h99);

    //            r0    r1    fwe     a0    a1    a2    d0     d1     d2     pend    wwe  wa    wd              e0            e1     es
    vecs[0]  = mk(5'd5, 5'd5, 3'b011, 5'd5, 5'd5, 5'd0, 32'h11, 32'h22, 32'h0, 3'b000, 1, 5'd5, 32'h33,         32'h11,       32'h11, 0);
    vecs[1]  = mk(5'd5, 5'd5, 3'b010, 5'd5, 5'd5, 5'd0, 32'h11, 32'h22, 32'h0, 3'b000, 1, 5'd5, 32'h33,         32'h22,       32'h22, 0);
    vecs[2]  = mk(5'd5, 5'd5, 3'b000, 5'd5, 5'd5, 5'd0, 32'h11, 32'h22, 32'h0, 3'b000, 1, 5'd5, 32'h33,         32'h33,       32'h33, 0);
    vecs[3]  = mk(5'd5, 5'd5, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0, 3'b000, 0, 5'd0, 32'h0,          32'h55,       32'h55, 0);
    vecs[4]  = mk(5'd9, 5'd8, 3'b001, 5'd8, 5'd0, 5'd0, 32'hAA, 32'h0,  32'h0, 3'b001, 0, 5'd0, 32'h0,          32'h99,       32'hAA, 1);
    vecs[5]  = mk(5'd9, 5'd9, 3'b001, 5'd8, 5'd0, 5'd0, 32'hAA, 32'h0,  32'h0, 3'b001, 0, 5'd0, 32'h0,          32'h99,       32'h99, 0);
    vecs[6]  = mk(5'd9, 5'd8, 3'b011, 5'd8, 5'd8, 5'd0, 32'hCC, 32'hBB, 32'h0, 3'b010, 0, 5'd0, 32'h0,          32'h99,       32'hCC, 0);
    vecs[7]  = mk(5'd0, 5'd0, 3'b111, 5'd0, 5'd0, 5'd0, 32'h5,  32'h6,  32'h7, 3'b111, 1, 5'd0, 32'hDEADBEEF,   32'h0,        32'h0,  0);
    vecs[8]  = mk(5'd8, 5'd9, 3'b011, 5'd9, 5'd8, 5'd0, 32'hCC, 32'hBB, 32'h0, 3'b010, 0, 5'd0, 32'h0,          32'hBB,       32'hCC, 1);
    vecs[9]  = mk(5'd8, 5'd5, 3'b000, 5'd0, 5'd0, 5'd8, 32'h0,  32'h0,  32'h0, 3'b100, 0, 5'd0, 32'h0,          32'h88,       32'h55, 0);
    vecs[10] = mk(5'd9, 5'd9, 3'b100, 5'd0, 5'd0, 5'd9, 32'h0,  32'h0,  32'h77, 3'b000, 0, 5'd0, 32'h0,         32'h77,       32'h77, 0);
    vecs[11] = mk(5'd8, 5'd5, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0, 3'b000, 1, 5'd8, 32'h12345678,   32'h12345678, 32'h55, 0);
    vecs[12] = mk(5'd5, 5'd9, 3'b100, 5'd0, 5'd0, 5'd5, 32'h0,  32'h0,  32'hEE, 3'b000, 1, 5'd5, 32'h33,        32'hEE,       32'h99, 0);

    // WB enable is dropped before each posedge so the vectors leave the array untouched
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      raddr = {vecs[i].r1, vecs[i].r0};
      set_fwd(vecs[i].fwe, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].d0, vecs[i].d1, vecs[i].d2);
      fwd_pending = vecs[i].pend;
      we = vecs[i].wwe; waddr = vecs[i].wa; wdata = vecs[i].wd;
      #1;
      chk($sformatf("vec%0d_rd0", i), rdata[31:0], vecs[i].e0);
      chk($sformatf("vec%0d_rd1", i), rdata[63:32], vecs[i].e1);
      chk($sformatf("vec%0d_stall", i), 32'(stall_req), 32'(vecs[i].es));
      #1;
      we = 1'b0;
    end

    // Write-through then persistence of r31
    @(negedge clk);
    idle();
    raddr = {5'd31, 5'd31};
    we = 1'b1; waddr = 5'd31; wdata = 32'hCAFEF00D;
    #1;
    chk("wt_r31_same_cycle", rdata[31:0], 32'hCAFEF00D);
    @(negedge clk);
    we = 1'b0;
    #1;
    chk("wt_r31_persist_p0", rdata[31:0], 32'hCAFEF00D);
    chk("wt_r31_persist_p1", rdata[63:32], 32'hCAFEF00D);

    // Committed write to r0 is discarded
    wb_write(5'd0, 32'hDEADBEEF);
    raddr = {5'd0, 5'd0};
    #1;
    chk("r0_after_write", rdata[31:0], 32'h0);
    chk("r0_stall", 32'(stall_req), 32'd0);

    // Unrelated addresses survived the vector phase unchanged
    raddr = {5'd9, 5'd8};
    #1;
    chk("persist_r8", rdata[31:0], 32'h88);
    chk("persist_r9", rdata[63:32], 32'h99);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
